fetch_stage_pipelined: RTL and testbench

- Pipelined RV32I fetch stage: owns the PC register, next-PC selection, the instruction-memory address, and the IF/ID pipeline register.
- Its `instr_d` output is the 32-bit instruction word consumed by the decode stage's control unit and register file.
- Redirects from execute (taken branch, JAL, JALR) and stall/flush requests from the hazard unit act here.
- Also keeps two free-running statistics counters for bench and performance checks.

---
 rtl/fetch_stage_pipelined_pkg.sv | 29 ++
 rtl/fetch_stage_pipelined_if.sv | 20 ++
 rtl/pipe_reg_en_clr.sv | 39 +++
 rtl/fetch_stage_pipelined.sv | 110 +++++++++++
 tb/tb_fetch_stage_pipelined.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pipelined_pkg.sv
// Shared pipeline definitions: default reset PC, bubble instruction and the IF/ID record
// that the decode stage consumes.
package fetch_stage_pipelined_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam int unsigned IF_ID_W = $bits(if_id_t);

    // Fields a bubble overwrites; the PC fields keep their previous contents.
    localparam if_id_t IF_ID_BUBBLE_MASK = '{
        instr:    '1,
        pc:       '0,
        pc_plus4: '0,
        valid:    1'b1
    };

    function automatic logic [31:0] align_pc(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_pipelined_if.sv
// Instruction-memory port: the fetch stage drives the address, memory answers combinationally.
interface fetch_stage_pipelined_if;

    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register with enable and masked clear; clear wins over enable.
module pipe_reg_en_clr #(
    parameter int unsigned       WIDTH    = 1,
    parameter logic [WIDTH-1:0]  RST_VAL  = '0,
    parameter logic [WIDTH-1:0]  CLR_VAL  = '0,
    parameter logic [WIDTH-1:0]  CLR_MASK = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            // Only masked bits take the clear value; the rest hold.
            q_d = (q_q & ~CLR_MASK) | (CLR_VAL & CLR_MASK);
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_stage_pipelined.sv
// RV32I fetch stage: PC register, next-PC selection, IF/ID register and fetch/flush statistics.
module fetch_stage_pipelined
    import fetch_stage_pipelined_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           stall_f,
    input  logic                           flush_d,
    input  logic                           redirect_e,
    input  logic [31:0]                    redirect_target_e,
    fetch_stage_pipelined_if.master        imem,
    output logic [31:0]                    instr_d,
    output logic [31:0]                    pc_d,
    output logic [31:0]                    pc_plus4_d,
    output logic                           valid_d,
    output logic [31:0]                    fetch_count,
    output logic [15:0]                    flush_count
);

    localparam if_id_t IF_ID_RST = '{
        instr:    NOP_INSTR,
        pc:       '0,
        pc_plus4: '0,
        valid:    1'b0
    };

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] fetch_pc_plus4;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic   kill;
    logic   load;
    logic   bubble;
    if_id_t if_id_in;
    if_id_t if_id_out;

    assign fetch_pc_plus4 = fetch_pc_q + 32'd4;

    // Redirect or flush discards the decode slot even when the hazard unit is stalling.
    assign kill   = flush_d | redirect_e;
    assign load   = ~kill & ~stall_f & imem.imem_ready;
    assign bubble = kill | (~stall_f & ~imem.imem_ready);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_e) begin
            fetch_pc_d = align_pc(redirect_target_e);
        end else if (!stall_f && imem.imem_ready) begin
            fetch_pc_d = fetch_pc_plus4;
        end
    end

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (load) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (kill) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        if_id_in          = IF_ID_RST;
        if_id_in.instr    = imem.imem_rdata;
        if_id_in.pc       = fetch_pc_q;
        if_id_in.pc_plus4 = fetch_pc_plus4;
        if_id_in.valid    = 1'b1;
    end

    pipe_reg_en_clr #(
        .WIDTH    (IF_ID_W),
        .RST_VAL  (IF_ID_RST),
        .CLR_VAL  (IF_ID_RST),
        .CLR_MASK (IF_ID_BUBBLE_MASK)
    ) u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load),
        .clr   (bubble),
        .d     (if_id_in),
        .q     (if_id_out)
    );

    assign imem.imem_addr = fetch_pc_q;
    assign instr_d        = if_id_out.instr;
    assign pc_d           = if_id_out.pc;
    assign pc_plus4_d     = if_id_out.pc_plus4;
    assign valid_d        = if_id_out.valid;
    assign fetch_count    = fetch_cnt_q;
    assign flush_count    = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage_pipelined.sv
// Bench for fetch_stage_pipelined: directed scenarios plus random traffic against a cycle model.
module tb_fetch_stage_pipelined;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [176:0] RESET_VEC = {RST_PC, NOP, 32'h0, 32'h0, 1'b0, 32'h0, 16'h0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_f = 1'b0;
    logic        flush_d = 1'b0;
    logic        redirect_e = 1'b0;
    logic [31:0] redirect_target_e = '0;
    logic [31:0] instr_d, pc_d, pc_plus4_d, fetch_count;
    logic        valid_d;
    logic [15:0] flush_count;
    logic [31:0] key;

    fetch_stage_pipelined_if bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ key;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    fetch_stage_pipelined dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_f           (stall_f),
        .flush_d           (flush_d),
        .redirect_e        (redirect_e),
        .redirect_target_e (redirect_target_e),
        .imem              (bus),
        .instr_d           (instr_d),
        .pc_d              (pc_d),
        .pc_plus4_d        (pc_plus4_d),
        .valid_d           (valid_d),
        .fetch_count       (fetch_count),
        .flush_count       (flush_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference state: what fetch and decode should hold.
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_fc;
    logic        m_valid;
    logic [15:0] m_flc;
    logic [176:0] got;

    assign got = {bus.imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_count, flush_count};

    function automatic logic [176:0] expv();
        return {m_pc, m_instr, m_pcd, m_pc4, m_valid, m_fc, m_flc};
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_instr = NOP; m_pcd = '0; m_pc4 = '0; m_valid = 1'b0;
        m_fc = '0; m_flc = '0;
    endtask

    // Apply one cycle of inputs, advance the model over the edge, return at edge+1.
    task automatic step(input logic st, input logic fl, input logic rd,
                        input logic [31:0] tgt, input logic rdy);
        logic [31:0] fetched;
        stall_f = st; flush_d = fl; redirect_e = rd; redirect_target_e = tgt;
        bus.imem_ready = rdy;
        fetched = mem_word(m_pc);
        @(posedge clk);
        if (rd || fl) begin
            m_instr = NOP; m_valid = 1'b0; m_flc = m_flc + 16'd1;
        end else if (!st) begin
            if (rdy) begin
                m_instr = fetched; m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_fc = m_fc + 32'd1;
            end else begin
                m_instr = NOP; m_valid = 1'b0;
            end
        end
        if (rd) m_pc = {tgt[31:2], 2'b00};
        else if (!st && rdy) m_pc = m_pc + 32'd4;
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.imem_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (got !== RESET_VEC) begin
            bad++; $display("FAIL reset_state got=%h want=%h", got, RESET_VEC);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        total++;
        if (bus.imem_addr !== RST_PC) begin
            bad++; $display("FAIL seq_first_addr got=%h want=%h", bus.imem_addr, RST_PC);
        end
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            total++;
            if (bus.imem_addr !== RST_PC + 32'(4 * i) || pc_d !== RST_PC + 32'(4 * (i - 1))
                || valid_d !== 1'b1 || instr_d !== mem_word(RST_PC + 32'(4 * (i - 1)))) begin
                bad++;
                $display("FAIL seq_step%0d got addr=%h pc_d=%h v=%b instr=%h", i,
                         bus.imem_addr, pc_d, valid_d, instr_d);
            end
        end
        total++;
        if (fetch_count !== 32'd4 || got !== expv()) begin
            bad++; $display("FAIL seq_count got=%0d want=4 vec=%h model=%h", fetch_count, got, expv());
        end
    endtask

    task automatic test_redirect();
        step(1'b0, 1'b0, 1'b1, 32'hBFC0_0103, 1'b1);
        total++;
        if (bus.imem_addr !== 32'hBFC0_0100 || valid_d !== 1'b0 || flush_count !== 16'd1) begin
            bad++;
            $display("FAIL redirect_n1 got addr=%h v=%b flc=%0d want BFC00100 0 1",
                     bus.imem_addr, valid_d, flush_count);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++;
        if (pc_d !== 32'hBFC0_0100 || valid_d !== 1'b1 || instr_d !== mem_word(32'hBFC0_0100)) begin
            bad++;
            $display("FAIL redirect_n2 got pc_d=%h v=%b instr=%h want BFC00100 1 %h",
                     pc_d, valid_d, instr_d, mem_word(32'hBFC0_0100));
        end
    endtask

    task automatic test_stall();
        logic [31:0] a, ins, fc;
        pulse_reset();
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        a = bus.imem_addr; ins = instr_d; fc = fetch_count;
        total++;
        if (a !== 32'hBFC0_0008) begin
            bad++; $display("FAIL stall_setup got=%h want=BFC00008", a);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            total++;
            if (bus.imem_addr !== a || instr_d !== ins || fetch_count !== fc || got !== expv()) begin
                bad++;
                $display("FAIL stall_hold%0d got addr=%h instr=%h fc=%0d want %h %h %0d", k,
                         bus.imem_addr, instr_d, fetch_count, a, ins, fc);
            end
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++;
        if (bus.imem_addr !== 32'hBFC0_000C || pc_d !== 32'hBFC0_0008) begin
            bad++; $display("FAIL stall_release got addr=%h pc_d=%h want BFC0000C BFC00008",
                            bus.imem_addr, pc_d);
        end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] tgt;
        tgt = $urandom;
        step(1'b1, 1'b0, 1'b1, tgt, 1'b1);
        total++;
        if (bus.imem_addr !== {tgt[31:2], 2'b00} || valid_d !== 1'b0 || instr_d !== NOP
            || got !== expv()) begin
            bad++; $display("FAIL stall_redirect got addr=%h v=%b want %h 0",
                            bus.imem_addr, valid_d, {tgt[31:2], 2'b00});
        end
    endtask

    task automatic test_not_ready();
        logic [31:0] a, fc, ins;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        a = bus.imem_addr; fc = fetch_count;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            total++;
            if (bus.imem_addr !== a || valid_d !== 1'b0 || fetch_count !== fc) begin
                bad++; $display("FAIL not_ready%0d got addr=%h v=%b fc=%0d want %h 0 %0d", k,
                                bus.imem_addr, valid_d, fetch_count, a, fc);
            end
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        ins = instr_d;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            total++;
            if (valid_d !== 1'b1 || instr_d !== ins || got !== expv()) begin
                bad++; $display("FAIL not_ready_stall%0d got v=%b instr=%h want 1 %h", k,
                                valid_d, instr_d, ins);
            end
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++;
        if (bus.imem_addr !== 32'h0 || pc_d !== 32'hFFFF_FFFC || pc_plus4_d !== 32'h0) begin
            bad++; $display("FAIL pc_wrap got addr=%h pc_d=%h pc4=%h want 0 FFFFFFFC 0",
                            bus.imem_addr, pc_d, pc_plus4_d);
        end
    endtask

    task automatic test_async_reset();
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (got !== RESET_VEC) begin
            bad++; $display("FAIL async_reset got=%h want=%h", got, RESET_VEC);
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++;
        if (pc_d !== RST_PC || valid_d !== 1'b1 || instr_d !== mem_word(RST_PC)
            || fetch_count !== 32'd1) begin
            bad++; $display("FAIL async_restart got pc_d=%h v=%b fc=%0d want %h 1 1",
                            pc_d, valid_d, fetch_count, RST_PC);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 4) != 0);
            total++;
            if (got !== expv()) begin
                bad++;
                if (errs < 10) $display("FAIL random_c%0d got=%h want=%h", c, got, expv());
                errs++;
            end
        end
    endtask

    initial begin
        key = $urandom;
        bus.imem_ready = 1'b0;
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_stall_redirect();
        test_not_ready();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
